seq_control_unit: RTL
=====================

// Module: seq_control_unit
// PURPOSE
//   Sequenced control unit for the basic accumulator CPU. Owns the sequence counter (SC),
//   the run flip-flop S and the registered opcode decode (D0..D7, I).
//   Emits every register/ALU/memory strobe for one instruction at a time. Adds SC clear,
//   halt/start, skip conditions and an optional interrupt cycle; address width is a parameter.
// PARAMETERS
//   ADDR_W   12   address field / AR,PC width; word width WORD_W = ADDR_W+4 (I + 3-bit opcode)
//   SC_W     3    sequence-counter width; T bus is 2**SC_W one-hot (min 3, T0..T6 used)
// PORTS
//   clk       in   1         system clock, rising edge
//   rst_n     in   1         synchronous active-low reset
//   start     in   1         pulse: set S (begin fetch at T0) when halted
//   ir        in   WORD_W    IR contents; [WORD_W-1]=I, [WORD_W-2:WORD_W-4]=opcode, [ADDR_W-1:0]=B
//   ac_zero   in   1         AC==0
//   ac_neg    in   1         AC MSB
//   dr_zero   in   1         DR==0 (sampled at T6 of ISZ, after increment)
//   e_bit     in   1         E flip-flop
//   fgi,fgo   in   1         input/output flags (used only with INTERRUPT_EN)
//   running   out  1         S flip-flop
//   t         out  2**SC_W   one-hot timing, all-zero when not running
//   d         out  8         registered opcode decode (one-hot)
//   {ar,pc,dr,ac,ir}_ctl out 3 each  {LD,INR,CLR} strobes
//   alu_op    out  12        {AND,ADD,LDA,CLE,CMA,CME,CIR,CIL,INC,CLA,ISZ,HLT}
//   mem_rd, mem_wr  out 1    memory read / write strobe
//   bus_sel   out  3         bus source: 1 AR,2 PC,3 DR,4 AC,5 IR,7 MEM, 0 none
// BEHAVIOUR
//   Reset: S=0, SC=0, d=0, i_q=0, R=0, IEN=0; all strobes/outputs 0.
//   All strobes gated by running; outputs combinational from SC, d, i_q, ir, flags.
//   SC increments every clk while running; sc_clr (end of instruction) loads 0 next cycle.
//   SC reaching 2**SC_W-1 without sc_clr is illegal: force SC=0 (no wrap into garbage).
//   start while running: ignored. start and rst_n=0 same cycle: reset wins.
//   Fetch: T0 bus=PC, AR.LD. T1 mem_rd, bus=MEM, IR.LD, PC.INR.
//   T2 bus=IR, AR.LD; d<=decode(opcode), i_q<=I registered at end of T2.
//   T3: D7=0 & I=1: mem_rd, AR.LD (indirect); D7=0 & I=0: nop.
//     D7=1 & I=0: register-ref per B bit, then sc_clr. D7=1 & I=1: I/O group, then sc_clr.
//   Memory-ref, sc_clr on last listed cycle:
//     AND/ADD/LDA: T4 mem_rd DR.LD; T5 alu_op, AC.LD.
//     STA: T4 bus=AC mem_wr.
//     BUN: T4 bus=AR PC.LD.
//     BSA: T4 bus=PC mem_wr AR.INR; T5 bus=AR PC.LD.
//     ISZ: T4 mem_rd DR.LD; T5 DR.INR; T6 bus=DR mem_wr, PC.INR iff dr_zero.
//   Register-ref skips (PC.INR at T3):
//     SPA B4 & !ac_neg; SNA B3 & ac_neg; SZA B2 & ac_zero; SZE B1 & !e_bit.
//   Several B bits set: all strobes asserted together; skips OR into a single PC.INR.
//   HLT (B0): S<=0 at end of T3; SC<=0; t goes all-zero next cycle.
// CONFIGURATION
//   INTERRUPT_EN defined:
//     IEN, R flip-flops. R<=1 when !T0&!T1&!T2 & IEN & (fgi|fgo).
//     With R=1 the next instruction boundary runs the interrupt cycle instead of fetch:
//       RT0 AR.CLR, bus=PC, DR.LD.
//       RT1 mem_wr (M[0]<=PC), PC.CLR.
//       RT2 PC.INR, IEN<=0, R<=0, sc_clr.
//     I/O group: INP B11, OUT B10; SKI B9 (skip if fgi); SKO B8 (skip if fgo).
//       ION B7 (IEN<=1), IOF B6 (IEN<=0).
//   INTERRUPT_EN undefined: no R/IEN. I/O group is a NOP that clears SC at T3; fgi/fgo ignored.
// TESTING
//   1 reset, start=0 10 cycles -> running=0, t=0, all strobes 0.
//   2 start; ir=0x2005 (LDA direct) -> T0..T5 strobes as listed.
//       AC.LD at T5, then t returns to T0 next cycle.
//   3 ir=0x7004 (SZA), ac_zero=1 -> PC.INR at T3, SC=0 next cycle.
//       ac_zero=0 -> no PC.INR.
//   4 ISZ, dr_zero=1 at T6 -> mem_wr and PC.INR together; dr_zero=0 -> mem_wr only.
//   5 ir=0x7001 (HLT) -> running falls after T3, t=0.
//       start re-pulse -> fetch resumes at T0. rst_n=0 mid-T4 -> all state 0 next clk.
//   6 INTERRUPT_EN: ION, then fgi=1 during T4 -> R set.
//       RT0..RT2 run next; M[0] written with PC, PC=1, IEN=0.

Source files
------------

// File: rtl/seq_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_control_unit: SC, run flop S and registered decode for the basic     |
// | accumulator CPU. INTERRUPT_EN adds IEN/R, interrupt cycle and I/O group.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module seq_control_unit #(
   parameter int ADDR_W = 12,
   parameter int SC_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W+3:0]     ir,
   input  logic                  ac_zero,
   input  logic                  ac_neg,
   input  logic                  dr_zero,
   input  logic                  e_bit,
   input  logic                  fgi,
   input  logic                  fgo,
   output logic                  running,
   output logic [(2**SC_W)-1:0]  t,
   output logic [7:0]            d,
   output logic [2:0]            ar_ctl,
   output logic [2:0]            pc_ctl,
   output logic [2:0]            dr_ctl,
   output logic [2:0]            ac_ctl,
   output logic [2:0]            ir_ctl,
   output logic [11:0]           alu_op,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [2:0]            bus_sel
);

   localparam int WORD_W = ADDR_W + 4;
   localparam int T_W    = 2**SC_W;
   localparam logic [SC_W-1:0] SC_MAX = {SC_W{1'b1}};

   localparam int LD  = 2;
   localparam int INR = 1;
   localparam int CLR = 0;

   localparam int ALU_AND = 11;
   localparam int ALU_ADD = 10;
   localparam int ALU_LDA = 9;
   localparam int ALU_CLE = 8;
   localparam int ALU_CMA = 7;
   localparam int ALU_CME = 6;
   localparam int ALU_CIR = 5;
   localparam int ALU_CIL = 4;
   localparam int ALU_INC = 3;
   localparam int ALU_CLA = 2;
   localparam int ALU_ISZ = 1;
   localparam int ALU_HLT = 0;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   logic            s_q, s_d;
   logic [SC_W-1:0] sc_q, sc_d;
   logic [7:0]      d_q, d_d;
   logic            i_q, i_d;
   logic            r_q;

   logic [T_W-1:0]  t_dec;
   logic [11:0]     b;
   logic [2:0]      op;
   logic            rr;
   logic            sc_clr;

   assign t_dec   = {{(T_W-1){1'b0}}, 1'b1} << sc_q;
   assign t       = s_q ? t_dec : '0;
   assign running = s_q;
   assign d       = d_q;
   assign b       = ir[11:0];
   assign op      = ir[WORD_W-2:WORD_W-4];
   assign rr      = t[3] & d_q[7] & ~i_q;

   assign sc_clr = (r_q & t[2]) | (t[3] & d_q[7])
                 | (t[4] & (d_q[3] | d_q[4]))
                 | (t[5] & (d_q[0] | d_q[1] | d_q[2] | d_q[5]))
                 | (t[6] & d_q[6]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q  <= 1'b0;
         sc_q <= '0;
         d_q  <= '0;
         i_q  <= 1'b0;
      end else begin
         s_q  <= s_d;
         sc_q <= sc_d;
         d_q  <= d_d;
         i_q  <= i_d;
      end
   end

   // Reaching SC_MAX without an end-of-instruction clear is illegal; fold back to T0.
   always_comb begin
      s_d  = s_q;
      sc_d = sc_q;
      d_d  = d_q;
      i_d  = i_q;
      if (!s_q) begin
         sc_d = '0;
         if (start) s_d = 1'b1;
      end else begin
         if (sc_clr || sc_q == SC_MAX) sc_d = '0;
         else                          sc_d = sc_q + SC_W'(1);
         if (rr && b[0]) s_d = 1'b0;
         if (t[2] && !r_q) begin
            d_d = 8'd1 << op;
            i_d = ir[WORD_W-1];
         end
      end
   end

`ifdef INTERRUPT_EN
   logic ien_q, ien_d, r_d, io;

   assign io = t[3] & d_q[7] & i_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q   <= 1'b0;
         ien_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         ien_q <= ien_d;
      end
   end

   always_comb begin
      r_d   = r_q;
      ien_d = ien_q;
      if (s_q && !(t[0] | t[1] | t[2]) && ien_q && (fgi | fgo)) r_d = 1'b1;
      if (r_q && t[2]) begin
         r_d   = 1'b0;
         ien_d = 1'b0;
      end
      if (io && b[7]) ien_d = 1'b1;
      if (io && b[6]) ien_d = 1'b0;
   end
`else
   logic unused_flags;
   assign r_q          = 1'b0;
   assign unused_flags = fgi ^ fgo;
`endif

   always_comb begin
      ar_ctl  = '0;
      pc_ctl  = '0;
      dr_ctl  = '0;
      ac_ctl  = '0;
      ir_ctl  = '0;
      alu_op  = '0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      bus_sel = BUS_NONE;
      if (r_q) begin
         // Interrupt cycle: save PC into M[0] through DR, then vector to address 1.
         if (t[0]) begin ar_ctl[CLR] = 1'b1; bus_sel = BUS_PC; dr_ctl[LD] = 1'b1; end
         if (t[1]) begin mem_wr = 1'b1; pc_ctl[CLR] = 1'b1; bus_sel = BUS_DR; end
         if (t[2]) pc_ctl[INR] = 1'b1;
      end else begin
         if (t[0]) begin bus_sel = BUS_PC; ar_ctl[LD] = 1'b1; end
         if (t[1]) begin
            mem_rd = 1'b1; bus_sel = BUS_MEM; ir_ctl[LD] = 1'b1; pc_ctl[INR] = 1'b1;
         end
         if (t[2]) begin bus_sel = BUS_IR; ar_ctl[LD] = 1'b1; end
      end
      if (t[3] && !d_q[7] && i_q) begin
         mem_rd = 1'b1; bus_sel = BUS_MEM; ar_ctl[LD] = 1'b1;
      end
      if (rr) begin
         alu_op[ALU_CLA] = b[11];
         alu_op[ALU_CLE] = b[10];
         alu_op[ALU_CMA] = b[9];
         alu_op[ALU_CME] = b[8];
         alu_op[ALU_CIR] = b[7];
         alu_op[ALU_CIL] = b[6];
         alu_op[ALU_INC] = b[5];
         alu_op[ALU_HLT] = b[0];
         ac_ctl[CLR]     = b[11];
         ac_ctl[LD]      = b[9] | b[7] | b[6];
         ac_ctl[INR]     = b[5];
         pc_ctl[INR]     = (b[4] & ~ac_neg) | (b[3] & ac_neg)
                         | (b[2] & ac_zero) | (b[1] & ~e_bit);
      end
`ifdef INTERRUPT_EN
      if (io) begin
         ac_ctl[LD]  = b[11];
         if (b[10]) bus_sel = BUS_AC;
         pc_ctl[INR] = (b[9] & fgi) | (b[8] & fgo);
      end
`endif
      if (t[4]) begin
         if (d_q[0] | d_q[1] | d_q[2] | d_q[6]) begin
            mem_rd = 1'b1; bus_sel = BUS_MEM; dr_ctl[LD] = 1'b1;
         end
         if (d_q[3]) begin bus_sel = BUS_AC; mem_wr = 1'b1; end
         if (d_q[4]) begin bus_sel = BUS_AR; pc_ctl[LD] = 1'b1; end
         if (d_q[5]) begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_ctl[INR] = 1'b1; end
      end
      if (t[5]) begin
         alu_op[ALU_AND] = d_q[0];
         alu_op[ALU_ADD] = d_q[1];
         alu_op[ALU_LDA] = d_q[2];
         ac_ctl[LD]      = d_q[0] | d_q[1] | d_q[2];
         if (d_q[5]) begin bus_sel = BUS_AR; pc_ctl[LD] = 1'b1; end
         if (d_q[6]) begin dr_ctl[INR] = 1'b1; alu_op[ALU_ISZ] = 1'b1; end
      end
      if (t[6] && d_q[6]) begin
         bus_sel = BUS_DR; mem_wr = 1'b1; pc_ctl[INR] = dr_zero;
      end
   end

endmodule
`default_nettype wire
